// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: pops a source FIFO, absorbs its 1-cycle read latency, forwards registered words.
// Optional: DRAIN_PARITY_EN adds a registered parity_out aligned with data_out/valid_out.
module fifo_drain_ctrl #(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [7:0]              umbral_alto_in,
  input  logic [7:0]              umbral_bajo_in,
  input  logic                    fifo_empty,
  input  logic                    fifo_error,
  input  logic [TAMANO_DATOS-1:0] fifo_data,
  input  logic                    dest_full,
  input  logic                    dest_almost_full,
  output logic                    fifo_read_enable,
  output logic [TAMANO_DATOS-1:0] data_out,
  output logic                    valid_out,
  output logic [7:0]              umbral_alto_out,
  output logic [7:0]              umbral_bajo_out,
  output logic [2:0]              state,
  output logic                    idle,
  output logic [CNT_WIDTH-1:0]    words_sent
`ifdef DRAIN_PARITY_EN
  ,
  output logic                    parity_out
`endif
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t cur_state, next_state;
  logic   rd_pending;
  logic   enter_init;
  logic   to_error;

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_RESET:  next_state = ST_INIT;
      ST_INIT:   if (!init) next_state = ST_IDLE;
      ST_IDLE: begin
        if (fifo_error)       next_state = ST_ERROR;
        else if (init)        next_state = ST_INIT;
        else if (!fifo_empty) next_state = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (fifo_error)                     next_state = ST_ERROR;
        else if (init)                      next_state = ST_INIT;
        else if (fifo_empty && !rd_pending) next_state = ST_IDLE;
      end
      ST_ERROR:  next_state = ST_ERROR;
      default:   next_state = ST_RESET;
    endcase
  end

  assign fifo_read_enable = (cur_state == ST_ACTIVE) && !fifo_empty && !dest_full &&
                            !dest_almost_full && !fifo_error;
  assign enter_init = (next_state == ST_INIT) && (cur_state != ST_INIT);
  // Gating on next_state keeps valid_out low from the first ERROR cycle and drops the in-flight word.
  assign to_error   = (next_state == ST_ERROR);
  assign state      = cur_state;
  assign idle       = (cur_state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= ST_RESET;
    else        cur_state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pending      <= 1'b0;
      valid_out       <= 1'b0;
      data_out        <= '0;
      umbral_alto_out <= '0;
      umbral_bajo_out <= '0;
      words_sent      <= '0;
`ifdef DRAIN_PARITY_EN
      parity_out      <= 1'b0;
`endif
    end else begin
      if (to_error) begin
        rd_pending <= 1'b0;
        valid_out  <= 1'b0;
      end else begin
        rd_pending <= fifo_read_enable;
        valid_out  <= rd_pending;
        if (rd_pending) begin
          data_out   <= fifo_data;
`ifdef DRAIN_PARITY_EN
          parity_out <= ^fifo_data;
`endif
        end
      end
      if (cur_state == ST_INIT) begin
        umbral_alto_out <= umbral_alto_in;
        umbral_bajo_out <= umbral_bajo_in;
      end
      if (enter_init)     words_sent <= '0;
      else if (valid_out) words_sent <= words_sent + CNT_WIDTH'(1);
    end
  end

endmodule
